// File: rtl/gameplay_pkg.sv
// Shared geometry, register widths and direction encoding for the gameplay datapath.
package gameplay_pkg;
  localparam int SCREEN_W = 160;
  localparam int BLOCK_W  = 16;
  localparam int ROW_H    = 4;
  localparam int BASE_Y   = 116;
  localparam int X_MAX    = SCREEN_W - BLOCK_W;
  localparam int MAX_ROW  = BASE_Y / ROW_H;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int ROW_W    = 5;
  localparam int SCORE_W  = 10;
  localparam int CH_W     = 4;
  localparam int PERIOD_W = 20;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/gameplay_datapath_block_shifter.sv
// Step-rate divider plus x/direction register; bounces the active block off both screen edges.
module block_shifter
  import gameplay_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                ld_x,
  input  logic                ld_d,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic [X_W-1:0]      x,
  output logic                dir
);
  logic [PERIOD_W-1:0] tick;
  logic                step;

  // >= rather than == so a period shortened below the live tick steps at once;
  // a period of 0 (deepest level at tiny BASE_PERIOD) steps every cycle.
  assign step = ({1'b0, tick} + (PERIOD_W+1)'(1)) >= {1'b0, period};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x    <= '0;
      dir  <= DIR_RIGHT;
      tick <= '0;
    end else begin
      if (ld_x) begin
        x    <= '0;
        tick <= '0;
      end else if (enable) begin
        if (step) begin
          tick <= '0;
          if (dir == DIR_RIGHT) begin
            if (x == X_W'(X_MAX)) begin
              x   <= X_W'(X_MAX - 1);
              dir <= DIR_LEFT;
            end else begin
              x <= x + X_W'(1);
            end
          end else begin
            if (x == '0) begin
              x   <= X_W'(1);
              dir <= DIR_RIGHT;
            end else begin
              x <= x - X_W'(1);
            end
          end
        end else begin
          tick <= tick + PERIOD_W'(1);
        end
      end
      if (ld_d) dir <= DIR_RIGHT;
    end
  end
endmodule

// File: rtl/gameplay_datapath.sv
// Gameplay datapath: executes one-cycle FSM commands and reports chances-left (c) and overlap (o).
module gameplay_datapath
  import gameplay_pkg::*;
#(
  parameter int CHANCES_INIT = 10,
  parameter int BASE_PERIOD  = 833333,
  parameter int LVL_ROWS     = 4,
  parameter int MAX_LVL      = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ld_x,
  input  logic               ld_y,
  input  logic               ld_d,
  input  logic               ld_df,
  input  logic               enable,
  input  logic               save_x,
  input  logic               inc_row,
  input  logic               inc_score,
  input  logic               dec_chances,
  output logic               c,
  output logic               o,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [X_W-1:0]     prev_x,
  output logic [ROW_W-1:0]   row,
  output logic [SCORE_W-1:0] score,
  output logic [CH_W-1:0]    chances
);
  logic [PERIOD_W-1:0] period;
  logic                prev_valid;
  logic                dir;
  logic [ROW_W-1:0]    lvl_raw;
  logic [ROW_W-1:0]    lvl;
  logic [X_W:0]        dx;

  block_shifter u_shifter (
    .clk    (clk),
    .resetn (resetn),
    .ld_x   (ld_x),
    .ld_d   (ld_d),
    .enable (enable),
    .period (period),
    .x      (x),
    .dir    (dir)
  );

  assign lvl_raw = row / ROW_W'(LVL_ROWS);
  assign lvl     = (lvl_raw > ROW_W'(MAX_LVL)) ? ROW_W'(MAX_LVL) : lvl_raw;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      y          <= Y_W'(BASE_Y);
      prev_x     <= '0;
      prev_valid <= 1'b0;
      row        <= '0;
      score      <= '0;
      chances    <= CH_W'(CHANCES_INIT);
      period     <= PERIOD_W'(BASE_PERIOD);
    end else begin
      if (ld_y)  y      <= Y_W'(BASE_Y - int'(row) * ROW_H);
      if (ld_df) period <= PERIOD_W'(BASE_PERIOD) >> lvl;
      if (save_x) begin
        prev_x     <= x;
        prev_valid <= 1'b1;
      end
      if (inc_row && row != ROW_W'(MAX_ROW)) row     <= row + ROW_W'(1);
      if (inc_score && score != '1)          score   <= score + SCORE_W'(1);
      if (dec_chances && chances != '0)      chances <= chances - CH_W'(1);
    end
  end

  // Touching edges (distance exactly BLOCK_W) do not count as overlap.
  assign dx = (x >= prev_x) ? ({1'b0, x} - {1'b0, prev_x}) : ({1'b0, prev_x} - {1'b0, x});
  assign o  = !prev_valid || (dx < (X_W+1)'(BLOCK_W));
  assign c  = (chances != '0);
endmodule

// File: tb/tb_gameplay_datapath.sv
// Directed scenarios plus random command traffic, checked every cycle against a behavioural model.
module tb_gameplay_datapath;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ld_x = 0, ld_y = 0, ld_d = 0, ld_df = 0, enable = 0;
  logic       save_x = 0, inc_row = 0, inc_score = 0, dec_chances = 0;
  logic       c, o;
  logic [7:0] x, prev_x;
  logic [6:0] y;
  logic [4:0] row;
  logic [9:0] score;
  logic [3:0] chances;

  int n_chk = 0, n_err = 0;
  int m_x, m_dir, m_tick, m_y, m_px, m_pv, m_row, m_score, m_ch, m_per;

  gameplay_datapath #(.CHANCES_INIT(10), .BASE_PERIOD(4), .LVL_ROWS(4), .MAX_LVL(3)) dut (
    .clk(clk), .resetn(resetn), .ld_x(ld_x), .ld_y(ld_y), .ld_d(ld_d), .ld_df(ld_df),
    .enable(enable), .save_x(save_x), .inc_row(inc_row), .inc_score(inc_score),
    .dec_chances(dec_chances), .c(c), .o(o), .x(x), .y(y), .prev_x(prev_x),
    .row(row), .score(score), .chances(chances)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: one clock edge of the game rules, all decisions from pre-edge state.
  task automatic model_edge();
    int ox, orow, nx, lvl;
    ox = m_x; orow = m_row;
    if (!resetn) begin
      m_x = 0; m_dir = 1; m_tick = 0; m_y = 116; m_px = 0; m_pv = 0;
      m_row = 0; m_score = 0; m_ch = 10; m_per = 4;
      return;
    end
    if (ld_x) begin
      m_x = 0; m_tick = 0;
    end else if (enable) begin
      m_tick++;
      if (m_tick >= m_per) begin
        m_tick = 0;
        nx = m_x + (m_dir ? 1 : -1);
        if (nx > 144) begin m_x = 288 - nx; m_dir = 0; end
        else if (nx < 0) begin m_x = -nx; m_dir = 1; end
        else m_x = nx;
      end
    end
    if (ld_d) m_dir = 1;
    if (ld_y) m_y = 116 - 4 * orow;
    if (ld_df) begin
      lvl = orow / 4;
      if (lvl > 3) lvl = 3;
      m_per = 4 >> lvl;
    end
    if (save_x) begin m_px = ox; m_pv = 1; end
    if (inc_row && m_row < 29) m_row++;
    if (inc_score && m_score < 1023) m_score++;
    if (dec_chances && m_ch > 0) m_ch--;
  endtask

  task automatic step();
    int d;
    @(posedge clk);
    model_edge();
    #1;
    d = (m_x > m_px) ? m_x - m_px : m_px - m_x;
    chk("x", x, m_x);
    chk("y", y, m_y);
    chk("prev_x", prev_x, m_px);
    chk("row", row, m_row);
    chk("score", score, m_score);
    chk("chances", chances, m_ch);
    chk("c", c, (m_ch != 0));
    chk("o", o, (!m_pv || d < 16));
  endtask

  task automatic clr();
    ld_x = 0; ld_y = 0; ld_d = 0; ld_df = 0;
    save_x = 0; inc_row = 0; inc_score = 0; dec_chances = 0;
  endtask

  task automatic run_to(input int target);
    int n = 0;
    enable = 1;
    while (x != target && n < 4000) begin step(); n++; end
    enable = 0;
    chk("run_to", x, target);
  endtask

  task automatic step_until_move(input string tag, input int want);
    int n = 0;
    logic [7:0] start;
    start = x;
    enable = 1;
    do begin step(); n++; end while (x == start && n < 20);
    enable = 0;
    chk(tag, x, want);
  endtask

  initial begin
    int n;
    m_x = 0; m_dir = 1; m_tick = 0; m_y = 116; m_px = 0; m_pv = 0;
    m_row = 0; m_score = 0; m_ch = 10; m_per = 4;

    // 1: reset values
    resetn = 0; step(); step();
    resetn = 1; step();
    chk("rst_x", x, 0); chk("rst_y", y, 116); chk("rst_row", row, 0);
    chk("rst_score", score, 0); chk("rst_ch", chances, 10);
    chk("rst_c", c, 1); chk("rst_o", o, 1);

    // 2: step rate and both bounces
    ld_x = 1; ld_d = 1; step(); clr();
    enable = 1; n = 0;
    do begin step(); n++; end while (x == 0 && n < 20);
    chk("step_gap", n, 4);
    run_to(144);
    step_until_move("bounce_r", 143);
    step_until_move("after_bounce_r", 142);
    run_to(0);
    step_until_move("bounce_l", 1);

    // 3: overlap window around prev_x=40
    ld_x = 1; ld_d = 1; step(); clr();
    run_to(40);
    save_x = 1; step(); clr();
    chk("prev_x40", prev_x, 40);
    run_to(55); chk("o_55", o, 1);
    run_to(56); chk("o_56", o, 0);
    run_to(25); chk("o_25", o, 1);
    run_to(24); chk("o_24", o, 0);

    // 4: success cycle, then ld_y picks up the new row
    save_x = 1; inc_row = 1; inc_score = 1; dec_chances = 1; step(); clr();
    chk("succ_row", row, 1); chk("succ_score", score, 1);
    chk("succ_ch", chances, 9); chk("succ_px", prev_x, 24);
    ld_y = 1; step(); clr();
    chk("y_row1", y, 112);

    // 5: saturation
    dec_chances = 1; repeat (10) step(); clr();
    chk("ch_zero", chances, 0); chk("c_zero", c, 0);
    dec_chances = 1; step(); clr();
    chk("ch_sat", chances, 0);
    inc_row = 1; repeat (40) step(); clr();
    chk("row_sat", row, 29);
    ld_y = 1; step(); clr();
    chk("y_top", y, 0);
    inc_score = 1; repeat (1030) step(); clr();
    chk("score_sat", score, 1023);

    // 6: level 2 speed, then reset mid-move
    resetn = 0; step(); resetn = 1;
    inc_row = 1; repeat (8) step(); clr();
    ld_x = 1; ld_d = 1; ld_df = 1; step(); clr();
    enable = 1; repeat (3) step();
    chk("fast_x", x, 3);
    resetn = 0; inc_score = 1; save_x = 1; step(); clr();
    chk("mid_rst_x", x, 0); chk("mid_rst_y", y, 116); chk("mid_rst_row", row, 0);
    chk("mid_rst_score", score, 0); chk("mid_rst_ch", chances, 10);
    chk("mid_rst_px", prev_x, 0); chk("mid_rst_o", o, 1);
    resetn = 1; enable = 0; step();

    // random command traffic against the model
    for (int i = 0; i < 3000; i++) begin
      resetn      = ($urandom_range(0, 199) != 0);
      enable      = ($urandom_range(0, 3) != 0);
      ld_x        = ($urandom_range(0, 31) == 0);
      ld_d        = ($urandom_range(0, 15) == 0);
      ld_y        = ($urandom_range(0, 7) == 0);
      ld_df       = ($urandom_range(0, 7) == 0);
      save_x      = ($urandom_range(0, 7) == 0);
      inc_row     = ($urandom_range(0, 3) == 0);
      inc_score   = ($urandom_range(0, 1) == 0);
      dec_chances = ($urandom_range(0, 15) == 0);
      step();
    end
    clr(); resetn = 1; enable = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
